// File: rtl/jk_count_sequencer_if.sv
// Command handshake between a controller (master) and the JK count sequencer (slave).
interface jk_count_sequencer_if #(
  parameter int WIDTH = 4
) ();
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_ready;

  modport master (output cmd_valid, cmd_op, cmd_target, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_target, output cmd_ready);
endinterface

// File: rtl/jk_count_sequencer.sv
// Drives a bank of external JK flip-flops through load, clear and up/down
// counting commands, using the flops' Q outputs as feedback.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1, J/K held at 0/0
// RUN   | driving J/K each cycle until load/clear, match, abort or timeout
// DONE  | one-cycle completion pulse, err/steps valid
module jk_count_sequencer #(
  parameter int WIDTH     = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              preset_n,
  jk_count_sequencer_if.slave cmd,
  input  logic              en,
  input  logic              abort,
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  j_out,
  output logic [WIDTH-1:0]  k_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        steps
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [7:0] MAX_Q    = 8'(MAX_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] target_q;
  logic [7:0]       steps_q;
  logic             err_q;
  logic             done_q;

  logic             match;
  logic             timeout;
  logic             is_count;
  logic             drive_cnt;
  logic [WIDTH-1:0] mask;
  logic             carry;

  assign match     = (q_in == target_q);
  assign timeout   = (steps_q >= MAX_Q);
  assign is_count  = (op_q == OP_UP) || (op_q == OP_DOWN);
  assign drive_cnt = (state_q == S_RUN) && is_count && !match && !abort && !timeout && en;

  // Ripple toggle mask: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    carry = 1'b1;
    mask  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = carry;
      carry   = carry & ((op_q == OP_DOWN) ? ~q_in[i] : q_in[i]);
    end
  end

  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state_q == S_RUN && !abort) begin
      case (op_q)
        OP_LOAD: begin
          j_out = target_q;
          k_out = ~target_q;
        end
        OP_CLEAR: k_out = '1;
        default: begin
          if (drive_cnt) begin
            j_out = mask;
            k_out = mask;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LOAD;
      target_q <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            op_q     <= cmd.cmd_op;
            target_q <= cmd.cmd_target;
            steps_q  <= '0;
            err_q    <= 1'b0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (!is_count) begin
            if (abort) err_q <= 1'b1;
            else       steps_q <= 8'd1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (match) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (abort || timeout) begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (en && steps_q != 8'hFF) begin
            steps_q <= steps_q + 8'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign steps         = steps_q;

endmodule

// File: tb/tb_jk_count_sequencer.sv
// Directed bench: the sequencer drives a 4-bit bank of modelled JK flops
// (MAX_STEPS=4 so the timeout path is reachable in a few cycles).
module tb_jk_count_sequencer;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk = 1'b0;
  logic       preset_n;
  logic       en;
  logic       abort;
  logic [3:0] q = 4'h0;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] steps;

  int total = 0;
  int bad   = 0;

  jk_count_sequencer_if #(.WIDTH(4)) cmd_if ();

  jk_count_sequencer #(.WIDTH(4), .MAX_STEPS(4)) dut (
    .clk      (clk),
    .preset_n (preset_n),
    .cmd      (cmd_if),
    .en       (en),
    .abort    (abort),
    .q_in     (q),
    .j_out    (j_out),
    .k_out    (k_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .steps    (steps)
  );

  always #5 clk = ~clk;

  // External JK flip-flop bank: Q+ = J&~Q | ~K&Q
  always @(posedge clk) q <= (j_out & ~q) | (~k_out & q);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer a command in IDLE; returns at the negedge of the first RUN cycle.
  task automatic start(input logic [1:0] op, input logic [3:0] tgt);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = op;
    cmd_if.cmd_target = tgt;
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b0;
  endtask

  // Returns at the negedge of the DONE cycle, or flags a missing done.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  logic [3:0] up_seq [3]  = '{4'hF, 4'h0, 4'h1};
  logic [3:0] dn_seq [5]  = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hD};
  logic       saw_done;

  initial begin
    preset_n          = 1'b0;
    en                = 1'b1;
    abort             = 1'b0;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = OP_LOAD;
    cmd_if.cmd_target = 4'h3;
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_if.cmd_ready, 1'b1);
    check("rst_busy",  busy,  1'b0);
    check("rst_done",  done,  1'b0);
    check("rst_err",   err,   1'b0);
    check("rst_steps", steps, 8'd0);
    check("rst_j",     j_out, 4'h0);
    check("rst_k",     k_out, 4'h0);

    // first accept on the first edge after release
    preset_n = 1'b1;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    check("first_busy", busy,  1'b1);
    check("first_j",    j_out, 4'h3);
    check("first_k",    k_out, 4'hC);
    wait_done();
    check("first_q", q, 4'h3);

    // CLEAR then LOAD A
    start(OP_CLEAR, 4'h5);
    check("clr_j", j_out, 4'h0);
    check("clr_k", k_out, 4'hF);
    wait_done();
    check("clr_q",     q,     4'h0);
    check("clr_steps", steps, 8'd1);

    start(OP_LOAD, 4'hA);
    check("load_j",     j_out, 4'hA);
    check("load_k",     k_out, 4'h5);
    check("load_ready", cmd_if.cmd_ready, 1'b0);
    wait_done();
    check("load_err",   err,   1'b0);
    check("load_steps", steps, 8'd1);
    check("load_q",     q,     4'hA);
    check("done_j",     j_out, 4'h0);
    check("done_k",     k_out, 4'h0);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_op     = OP_UP;
    cmd_if.cmd_target = 4'h0;
    @(negedge clk);
    check("no_accept_in_done", busy, 1'b0);
    check("done_pulse_len",    done, 1'b0);
    cmd_if.cmd_valid = 1'b0;

    // UP E -> 1 with wrap
    start(OP_LOAD, 4'hE);
    wait_done();
    start(OP_UP, 4'h1);
    check("up_j0", j_out, 4'h1);
    check("up_k0", k_out, 4'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("up_q%0d", i), q, up_seq[i]);
    end
    wait_done();
    check("up_steps", steps, 8'd3);
    check("up_err",   err,   1'b0);

    // DOWN 0 -> D with en low on alternate cycles
    start(OP_CLEAR, 4'h0);
    wait_done();
    start(OP_DOWN, 4'hD);
    check("dn_j0", j_out, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = (i % 2 == 1);
      #1;
      check($sformatf("dn_q%0d", i), q, dn_seq[i]);
      if (!en) begin
        check($sformatf("dn_idle_j%0d", i), j_out, 4'h0);
        check($sformatf("dn_idle_k%0d", i), k_out, 4'h0);
      end
    end
    en = 1'b1;
    wait_done();
    check("dn_steps", steps, 8'd3);
    check("dn_err",   err,   1'b0);

    // timeout after MAX_STEPS=4 drives
    start(OP_CLEAR, 4'h0);
    wait_done();
    start(OP_UP, 4'h9);
    wait_done();
    check("to_err",   err,   1'b1);
    check("to_steps", steps, 8'd4);
    check("to_q",     q,     4'h4);

    // abort on the second RUN cycle
    start(OP_CLEAR, 4'h0);
    wait_done();
    start(OP_UP, 4'hF);
    @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_j", j_out, 4'h0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_done",  done,  1'b1);
    check("abort_err",   err,   1'b1);
    check("abort_steps", steps, 8'd1);
    check("abort_q",     q,     4'h1);

    // abort coinciding with a match: match wins
    abort = 1'b1;
    start(OP_UP, 4'h1);
    wait_done();
    abort = 1'b0;
    check("abm_err",   err,   1'b0);
    check("abm_steps", steps, 8'd0);

    // reset mid-UP
    start(OP_CLEAR, 4'h0);
    wait_done();
    start(OP_UP, 4'h9);
    @(negedge clk);
    preset_n = 1'b0;
    #1;
    check("prst_j",     j_out, 4'h0);
    check("prst_k",     k_out, 4'h0);
    check("prst_busy",  busy,  1'b0);
    check("prst_ready", cmd_if.cmd_ready, 1'b1);
    check("prst_steps", steps, 8'd0);
    @(negedge clk);
    preset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("prst_no_done",    saw_done, 1'b0);
    check("prst_ready_after", cmd_if.cmd_ready, 1'b1);
    check("prst_q",          q, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
